// File: rtl/sum_normalizer.sv
// Post-add normalization stage: converts the adder's two's-complement sum to
// sign-magnitude and normalizes the leading one to bit 7 under a valid/ready handshake.
module sum_normalizer #(
  parameter int EXP_W = 5,
  parameter int SUM_W = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SUM_W-1:0] in_sum,
  input  logic [EXP_W-1:0] in_exp,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_sign,
  output logic [EXP_W-1:0] out_exp,
  output logic [SUM_W-3:0] out_man,
  output logic             out_zero,
  output logic             out_unf,
  output logic             out_ovf
);

  // state | meaning
  // IDLE  | waiting for an input sum, in_ready high
  // NORM  | one normalization step per cycle (right shift, left shift or terminal check)
  // DONE  | result presented, waiting for out_ready
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] NORM = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [EXP_W-1:0] EXP_ONE = 1;
  localparam logic [EXP_W-1:0] EXP_MAX = '1;

  logic [1:0]       state_q, state_d;
  logic             sign_q, sign_d;
  logic [EXP_W-1:0] exp_q, exp_d;
  logic [SUM_W-2:0] mag_q, mag_d;
  logic             zero_q, zero_d;
  logic             unf_q, unf_d;
  logic             ovf_q, ovf_d;

  logic [SUM_W-1:0] neg_sum;
  logic [SUM_W-2:0] in_mag;

  // The most negative sum has no representable magnitude; saturate it.
  always_comb begin
    neg_sum = -in_sum;
    in_mag  = in_sum[SUM_W-2:0];
    if (in_sum[SUM_W-1]) begin
      if (neg_sum[SUM_W-1]) in_mag = '1;
      else                  in_mag = neg_sum[SUM_W-2:0];
    end
  end

  assign in_ready = (state_q == IDLE) && !rst;

  always_comb begin
    state_d = state_q;
    sign_d  = sign_q;
    exp_d   = exp_q;
    mag_d   = mag_q;
    zero_d  = zero_q;
    unf_d   = unf_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = NORM;
          sign_d  = in_sum[SUM_W-1];
          mag_d   = in_mag;
          exp_d   = in_exp;
          zero_d  = 1'b0;
          unf_d   = 1'b0;
          ovf_d   = 1'b0;
        end
      end
      NORM: begin
        if (mag_q == '0) begin
          sign_d  = 1'b0;
          exp_d   = '0;
          zero_d  = 1'b1;
          state_d = DONE;
        end else if (mag_q[SUM_W-2] && exp_q == EXP_MAX) begin
          mag_d   = '0;
          ovf_d   = 1'b1;
          state_d = DONE;
        end else if (mag_q[SUM_W-2]) begin
          mag_d   = {1'b0, mag_q[SUM_W-2:1]};
          exp_d   = exp_q + EXP_ONE;
          state_d = DONE;
        end else if (mag_q[SUM_W-3]) begin
          state_d = DONE;
        end else if (exp_q == '0) begin
          unf_d   = 1'b1;
          state_d = DONE;
        end else begin
          mag_d   = {mag_q[SUM_W-3:0], 1'b0};
          exp_d   = exp_q - EXP_ONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sign_q  <= 1'b0;
      exp_q   <= '0;
      mag_q   <= '0;
      zero_q  <= 1'b0;
      unf_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sign_q  <= sign_d;
      exp_q   <= exp_d;
      mag_q   <= mag_d;
      zero_q  <= zero_d;
      unf_q   <= unf_d;
      ovf_q   <= ovf_d;
    end
  end

  assign out_valid = (state_q == DONE);
  assign out_sign  = sign_q;
  assign out_exp   = exp_q;
  assign out_man   = mag_q[SUM_W-3:0];
  assign out_zero  = zero_q;
  assign out_unf   = unf_q;
  assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_sum_normalizer.sv
// Directed bench for sum_normalizer: arithmetic reference model, per-cycle output
// compare while out_valid, latency/handshake checks and literal pins for the model.
module tb_sum_normalizer;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [9:0] in_sum;
  logic [4:0] in_exp;
  logic       out_valid;
  logic       out_ready;
  logic       out_sign;
  logic [4:0] out_exp;
  logic [7:0] out_man;
  logic       out_zero, out_unf, out_ovf;

  int tests = 0;
  int fails = 0;

  // model expectations for the operation in flight
  int m_sign, m_exp, m_man, m_zero, m_unf, m_ovf, m_k;

  sum_normalizer #(.EXP_W(5), .SUM_W(10)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_sum(in_sum), .in_exp(in_exp),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sign(out_sign), .out_exp(out_exp), .out_man(out_man),
    .out_zero(out_zero), .out_unf(out_unf), .out_ovf(out_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Reference: magnitude as an integer, then normalize by arithmetic.
  task automatic model(input int s, input int e);
    int m;
    m = (s < 0) ? -s : s;
    if (m > 511) m = 511;
    m_sign = (s < 0) ? 1 : 0;
    m_exp = e; m_zero = 0; m_unf = 0; m_ovf = 0; m_k = 0;
    if (m == 0) begin
      m_sign = 0; m_exp = 0; m_zero = 1;
    end else if (m >= 256) begin
      if (e == 31) begin m = 0; m_ovf = 1; end
      else begin m = m / 2; m_exp = e + 1; end
    end else begin
      while (m < 128 && m_exp > 0) begin
        m = m * 2; m_exp = m_exp - 1; m_k++;
      end
      if (m < 128) m_unf = 1;
    end
    m_man = m;
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid) begin
      chk("cmp_sign", out_sign, m_sign);
      chk("cmp_exp", out_exp, m_exp);
      chk("cmp_man", out_man, m_man);
      chk("cmp_zero", out_zero, m_zero);
      chk("cmp_unf", out_unf, m_unf);
      chk("cmp_ovf", out_ovf, m_ovf);
      chk("cmp_in_ready_busy", in_ready, 0);
    end
  end

  // Drive one operation; lit_* < 0 means no literal pin for that field.
  task automatic run_op(input int s, input int e, input int hold,
                        input int lit_sign, input int lit_exp, input int lit_man,
                        input int lit_lat);
    int n;
    model(s, e);
    @(negedge clk);
    chk("pre_in_ready", in_ready, 1);
    in_valid = 1'b1;
    in_sum = 10'(s);
    in_exp = 5'(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_sum = 10'($urandom);
    in_exp = 5'($urandom);
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("latency", n, m_k + 1);
    if (lit_lat >= 0) chk("lit_latency", n, lit_lat);
    if (lit_sign >= 0) chk("lit_sign", out_sign, lit_sign);
    if (lit_exp >= 0) chk("lit_exp", out_exp, lit_exp);
    if (lit_man >= 0) chk("lit_man", out_man, lit_man);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("bp_valid_held", out_valid, 1);
      chk("bp_in_ready", in_ready, 0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("post_valid", out_valid, 0);
    chk("post_in_ready", in_ready, 1);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_sum = '0; in_exp = '0; out_ready = 1'b0;
    model(0, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_outs", {out_sign, out_exp, out_man, out_zero, out_unf, out_ovf}, 0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_release_in_ready", in_ready, 1);

    // directed plan with literal pins (latency = edges after accept edge)
    run_op(510, 10, 0, 0, 11, 8'hFF, 1);
    run_op(-63, 15, 5, 1, 13, 8'hFC, 3);
    run_op(0, 20, 0, 0, 0, 0, 1);
    chk("lit_zero_flag", m_zero, 1);
    run_op(1, 3, 0, 0, 0, 8'h08, 4);
    chk("lit_unf_flag", m_unf, 1);
    run_op(300, 31, 2, 0, 31, 0, 1);
    chk("lit_ovf_flag", m_ovf, 1);

    // boundaries: clamp, exact leading one at exp 0, immediate underflow, max shifts
    run_op(-512, 4, 0, 1, 5, 8'hFF, 1);
    run_op(128, 0, 0, 0, 0, 8'h80, 1);
    run_op(-1, 0, 0, 1, 0, 8'h01, 1);
    run_op(1, 20, 0, 0, 13, 8'h80, 8);
    run_op(256, 30, 0, 0, 31, 8'h80, 1);
    run_op(-300, 31, 1, 1, 31, 0, 1);
    for (int i = 0; i < 12; i++)
      run_op(int'($urandom_range(0, 1023)) - 512, int'($urandom_range(0, 31)), i % 3,
             -1, -1, -1, -1);

    // reset in the middle of normalization discards the operation
    model(1, 3);
    @(negedge clk);
    in_valid = 1'b1; in_sum = 10'd1; in_exp = 5'd3;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 0);
    chk("midrst_outs", {out_sign, out_exp, out_man, out_zero, out_unf, out_ovf}, 0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    chk("midrst_release_in_ready", in_ready, 1);
    chk("midrst_release_valid", out_valid, 0);

    run_op(-63, 15, 0, 1, 13, 8'hFC, 3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
